booth_seq_mul: RTL and testbench
================================

Name: booth_seq_mul

Overview:
- Iterative signed radix-4 Booth multiplier controller.
- Sequences one partial-product row per clock through a single Booth digit selector and a shared accumulator.
- Produces the 2N-bit product after N/2 compute cycles.
- Sits between a valid/ready operand source and a valid/ready result sink. Replaces a full parallel array where area matters more than throughput.

Parameters:
- N, 10, operand width in bits (signed two's complement). Must be even and >= 4; elaboration-time assertion otherwise.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- a_in  in  N  multiplicand, signed
- b_in  in  N  multiplier, signed
- out_valid  out  1  product valid
- out_ready  in  1  sink accepts product
- product  out  2N  signed a*b
- busy  out  1  high in CALC or DONE

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; in_ready=1 after reset; out_valid=0, product=0, busy=0; counter, accumulator, multiplier and q_m1 registers all 0.
- Reset mid-operation aborts the operation with no output produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch A=a_in, load B register with b_in, q_m1=0, acc (N+2 bits)=0, step counter=0; go to CALC.
- CALC (in_ready=0):
  - Each cycle, digit = {B[1],B[0],q_m1}.
  - Digit selector returns row (N+1 bits) and neg:
    - 000, 111 -> 0, neg 0.
    - 001, 010 -> sign-extended A, neg 0.
    - 011 -> A<<1, neg 0.
    - 100 -> ~(A<<1), neg 1.
    - 101, 110 -> ~sext(A), neg 1.
  - acc_next = acc + sext_{N+2}(row) + neg (neg is the carry-in completing two's complement).
  - Then {acc,B,q_m1} is arithmetically shifted right by 2 as one (2N+3)-bit register.
  - Counter increments. After step N/2-1 completes, go to DONE.
- DONE:
  - out_valid=1; product = {acc[N-1:0], B}, registered and stable while waiting.
  - On out_ready: go to IDLE next cycle, out_valid=0.
- Latency: handshake in cycle t -> compute cycles t+1..t+N/2 -> out_valid asserted from cycle t+N/2+1.
- Throughput: one result per N/2+2 cycles minimum. No operand acceptance until the result is consumed.
- in_valid asserted outside IDLE is ignored. a_in/b_in changes after acceptance have no effect.
- out_ready outside DONE is ignored. out_valid holds indefinitely under back-pressure.
- Width rules:
  - acc is N+2 bits so ±2A never overflows.
  - Full-range corner (-2^(N-1))*(-2^(N-1)) = 2^(2N-2) fits in the 2N-bit signed result.
- No X propagation: all registers are reset. Digit selector default arm outputs 0, neg 0.

Decomposition:
- Package booth_pkg:
  - state enum type (IDLE, CALC, DONE).
  - localparam function for counter width, $clog2(N/2)+1.
  - Booth digit encoding constants.
- Sub-module booth_digit_sel (combinational): sel[2:0], A[N-1:0] -> row[N:0], neg. Instantiated once; the controller owns counter, shift register and accumulator.

Test Plan:
- N=10, a=3, b=5 -> product=15; out_valid rises exactly 6 cycles after the accept edge.
- a=-512, b=-512 -> product=262144; a=-512, b=511 -> -261632; a=511, b=511 -> 261121.
- a=0, b=-1 and a=-1, b=-1 -> 0 and 1; in_valid held high throughout, in_ready low from CALC entry until the IDLE return.
- Back-pressure: out_ready=0 for 10 cycles in DONE -> out_valid and product stable; pulse out_ready -> IDLE next cycle, next operands accepted.
- rst asserted at step 2 of CALC -> next cycle IDLE, out_valid=0, busy=0; new pair 7*-9 completes with -63.
- 10k random signed pairs, back-to-back with random out_ready -> every product matches reference a*b; no operand dropped or duplicated.

Source files
------------

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - state type, counter sizing and Booth digit codes for booth_seq_mul
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Booth digit {b[i+1], b[i], b[i-1]} codes
  localparam logic [2:0] DIG_ZERO_A = 3'b000;
  localparam logic [2:0] DIG_P1_A   = 3'b001;
  localparam logic [2:0] DIG_P1_B   = 3'b010;
  localparam logic [2:0] DIG_P2     = 3'b011;
  localparam logic [2:0] DIG_M2     = 3'b100;
  localparam logic [2:0] DIG_M1_A   = 3'b101;
  localparam logic [2:0] DIG_M1_B   = 3'b110;
  localparam logic [2:0] DIG_ZERO_B = 3'b111;

  function automatic int cnt_width(input int n);
    return $clog2(n / 2) + 1;
  endfunction

endpackage

// File: rtl/booth_digit_sel.sv
// rtl/booth_digit_sel.sv - radix-4 Booth digit to partial-product row selector
module booth_digit_sel
  import booth_pkg::*;
#(
  parameter int N = 10
) (
  input  logic [2:0]   sel_i,
  input  logic [N-1:0] a_i,
  output logic [N:0]   row_o,
  output logic         neg_o
);

  logic [N:0] a_sx;
  logic [N:0] a_x2;

  assign a_sx = {a_i[N-1], a_i};
  assign a_x2 = {a_i, 1'b0};

  // Negative digits return the one's complement; neg_o is the +1 carry-in
  always_comb begin
    row_o = '0;
    neg_o = 1'b0;
    case (sel_i)
      DIG_ZERO_A, DIG_ZERO_B: begin
        row_o = '0;
        neg_o = 1'b0;
      end
      DIG_P1_A, DIG_P1_B: row_o = a_sx;
      DIG_P2:             row_o = a_x2;
      DIG_M2: begin
        row_o = ~a_x2;
        neg_o = 1'b1;
      end
      DIG_M1_A, DIG_M1_B: begin
        row_o = ~a_sx;
        neg_o = 1'b1;
      end
      default: begin
        row_o = '0;
        neg_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/booth_seq_mul.sv
// rtl/booth_seq_mul.sv - iterative signed radix-4 Booth multiplier, one row per clock
module booth_seq_mul
  import booth_pkg::*;
#(
  parameter int N = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  localparam int            CW        = cnt_width(N);
  localparam logic [CW-1:0] LAST_STEP = CW'(N / 2 - 1);

  generate
    if ((N % 2) != 0 || N < 4) begin : g_bad_n
      $error("booth_seq_mul: N must be even and >= 4");
    end
  endgenerate

  state_e         state_q, state_d;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q, b_d;
  logic [N+1:0]   acc_q, acc_d;
  logic           qm1_q, qm1_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N:0]     row;
  logic           neg;
  logic [N+1:0]   sum;
  logic [2*N+2:0] shifted;
  logic           accept;

  assign accept = in_valid && (state_q == IDLE);

  booth_digit_sel #(.N(N)) u_digit_sel (
    .sel_i ({b_q[1:0], qm1_q}),
    .a_i   (a_q),
    .row_o (row),
    .neg_o (neg)
  );

  // acc is N+2 bits wide so the +/-2A row never overflows before the shift
  assign sum     = acc_q + {row[N], row} + {{(N + 1){1'b0}}, neg};
  assign shifted = $signed({sum, b_q, qm1_q}) >>> 2;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CALC;
      CALC:    if (cnt_q == LAST_STEP) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == CALC) || (state_q == DONE);
  end

  always_comb begin
    acc_d = acc_q;
    b_d   = b_q;
    qm1_d = qm1_q;
    cnt_d = cnt_q;
    if (accept) begin
      acc_d = '0;
      b_d   = b_in;
      qm1_d = 1'b0;
      cnt_d = '0;
    end else if (state_q == CALC) begin
      acc_d = shifted[2*N+2:N+1];
      b_d   = shifted[N:1];
      qm1_d = shifted[0];
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      qm1_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (accept) a_q <= a_in;
      b_q   <= b_d;
      acc_q <= acc_d;
      qm1_q <= qm1_d;
      cnt_q <= cnt_d;
    end
  end

  // acc and B hold still in DONE, so the product is stable under back-pressure
  assign product = {acc_q[N-1:0], b_q};

endmodule

// File: tb/tb_booth_seq_mul.sv
// tb/tb_booth_seq_mul.sv - directed and random checks for booth_seq_mul
module tb_booth_seq_mul;

  localparam int N     = 10;
  localparam int NRAND = 10000;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a_in;
  logic [N-1:0]   b_in;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] product;
  logic           busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  booth_seq_mul #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int prod_s();
    return int'($signed(product));
  endfunction

  // Entered and left on a negedge; keep leaves in_valid high for a back-to-back call
  task automatic do_op(input int a, input int b, input int exp, input string tag,
                       input int stall, input bit keep);
    int n;
    int lat;
    int first;
    bit rdy_ok;
    bit stable;
    a_in     = N'(a);
    b_in     = N'(b);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept"}, int'(in_ready), 1);
    lat    = 0;
    rdy_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (in_ready) rdy_ok = 1'b0;
      if (lat == 1) begin
        a_in = ~a_in;
        b_in = ~b_in;
      end
    end while (!out_valid && lat < 50);
    check({tag, "_latency"}, lat, 6);
    check({tag, "_inready_low"}, int'(rdy_ok), 1);
    if (stall > 0) begin
      first  = prod_s();
      stable = 1'b1;
      repeat (stall) begin
        @(negedge clk);
        if (!out_valid || prod_s() != first || in_ready) stable = 1'b0;
      end
      check({tag, "_hold"}, int'(stable), 1);
    end
    check({tag, "_product"}, prod_s(), exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_ovalid"}, int'(out_valid), 0);
    check({tag, "_idle_inready"}, int'(in_ready), 1);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic random_run();
    logic signed [N-1:0] ra;
    logic signed [N-1:0] rb;
    int q[$];
    int sent;
    int got;
    int cyc;
    bit acc_pend;
    ra = N'($urandom);
    rb = N'($urandom);
    a_in = ra;
    b_in = rb;
    in_valid = 1'b1;
    sent = 0;
    got  = 0;
    cyc  = 0;
    acc_pend = 1'b0;
    while (got < NRAND && cyc < 90000) begin
      if (acc_pend) begin
        q.push_back(int'(ra) * int'(rb));
        sent++;
        if (sent < NRAND) begin
          ra = N'($urandom);
          rb = N'($urandom);
          a_in = ra;
          b_in = rb;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 7) != 0);
      acc_pend  = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("rand_extra_result", 1, 0);
        else               check("rand_product", prod_s(), q.pop_front());
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("rand_results", got, NRAND);
    check("rand_sent", sent, NRAND);
    check("rand_leftover", q.size(), 0);
  endtask

  initial begin
    bit ov;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    repeat (3) @(negedge clk);
    check("rst_inready", int'(in_ready), 1);
    check("rst_outvalid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_product", int'(product), 0);
    rst = 1'b0;

    do_op(3, 5, 15, "3x5", 0, 1'b0);
    do_op(-512, -512, 262144, "min_x_min", 0, 1'b0);
    do_op(-512, 511, -261632, "min_x_max", 0, 1'b0);
    do_op(511, 511, 261121, "max_x_max", 0, 1'b0);
    do_op(0, -1, 0, "0_x_m1", 0, 1'b1);
    do_op(-1, -1, 1, "m1_x_m1", 0, 1'b0);
    do_op(-300, 7, -2100, "stall", 10, 1'b0);

    a_in     = N'(100);
    b_in     = N'(100);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_inready", int'(in_ready), 1);
    check("abort_outvalid", int'(out_valid), 0);
    check("abort_busy", int'(busy), 0);
    ov = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) ov = 1'b1;
    end
    check("abort_no_output", int'(ov), 0);
    do_op(7, -9, -63, "after_abort", 0, 1'b0);

    random_run();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
